// File: rtl/serial_add_sub_unit_if.sv
// serial_add_sub_unit_if: operand/result valid-ready bundle for the serial add/sub unit
interface serial_add_sub_unit_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, op, out_valid, out_ready, overflow;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0] sum;
  modport master(output in_valid, a, b, op, out_ready, input in_ready, out_valid, sum, overflow);
  modport slave(input in_valid, a, b, op, out_ready, output in_ready, out_valid, sum, overflow);
endinterface

// File: rtl/serial_add_sub_unit.sv
// serial_add_sub_unit: multi-cycle a +/- b over WIDTH bits, CHUNK bits per clock,
// carry held in a register between chunks; valid/ready on both sides.
module serial_add_sub_unit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input logic clk,
  input logic rst_n,
  serial_add_sub_unit_if.slave io
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("serial_add_sub_unit: WIDTH must be >= 2 and a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH:0] sum_r;
  logic [CW-1:0] cnt;
  logic [CHUNK:0] part;
  logic carry, in_ready_r, out_valid_r, ovf_r, msb_cin;
  assign part = {1'b0, a_r[cnt*CHUNK +: CHUNK]} + {1'b0, b_r[cnt*CHUNK +: CHUNK]} + (CHUNK+1)'(carry);
  // only meaningful on the last chunk: recovers the carry into the MSB from its sum bit
  assign msb_cin = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ part[CHUNK-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
      sum_r <= '0;
      ovf_r <= 1'b0;
      carry <= 1'b0;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
    end else
      case (state)
        IDLE: if (io.in_valid) begin
          a_r <= io.a;
          b_r <= io.op ? ~io.b : io.b;
          carry <= io.op;
          cnt <= '0;
          in_ready_r <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          sum_r[cnt*CHUNK +: CHUNK] <= part[CHUNK-1:0];
          carry <= part[CHUNK];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NCH - 1)) begin
            sum_r[WIDTH] <= part[CHUNK];
            ovf_r <= msb_cin ^ part[CHUNK];
            out_valid_r <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (io.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  assign io.in_ready = in_ready_r;
  assign io.out_valid = out_valid_r;
  assign io.sum = sum_r;
  assign io.overflow = ovf_r;
endmodule

// File: tb/tb_serial_add_sub_unit.sv
// tb_serial_add_sub_unit: vector table, corner sequences and randomized ops against
// an arithmetic reference model, on a CHUNK=1 and a CHUNK=4 instance (WIDTH=8).
module tb_serial_add_sub_unit;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic in_valid = 1'b0, op = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic in_ready_m, out_valid_m, ovf_m;
  logic [8:0] sum_m;
  int n_cmp = 0, n_bad = 0;

  serial_add_sub_unit_if #(.WIDTH(8)) f1 ();
  serial_add_sub_unit_if #(.WIDTH(8)) f4 ();
  serial_add_sub_unit #(.WIDTH(8), .CHUNK(1)) u1 (.clk(clk), .rst_n(rst_n), .io(f1));
  serial_add_sub_unit #(.WIDTH(8), .CHUNK(4)) u4 (.clk(clk), .rst_n(rst_n), .io(f4));

  assign f1.in_valid = in_valid & ~sel;
  assign f4.in_valid = in_valid & sel;
  assign f1.a = a;
  assign f4.a = a;
  assign f1.b = b;
  assign f4.b = b;
  assign f1.op = op;
  assign f4.op = op;
  assign f1.out_ready = out_ready;
  assign f4.out_ready = out_ready;
  assign in_ready_m = sel ? f4.in_ready : f1.in_ready;
  assign out_valid_m = sel ? f4.out_valid : f1.out_valid;
  assign sum_m = sel ? f4.sum : f1.sum;
  assign ovf_m = sel ? f4.overflow : f1.overflow;

  always #5 clk = ~clk;

  typedef struct {
    bit o;
    logic [7:0] x, y;
    logic [8:0] s;
    bit v;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference: plain unsigned / signed arithmetic on the operands
  function automatic logic [9:0] model(input bit o, input logic [7:0] x, input logic [7:0] y);
    int r, s;
    logic [8:0] t;
    r = o ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    s = o ? int'(x) + 256 - int'(y) : int'(x) + int'(y);
    t = 9'(s);
    return {r > 127 || r < -128, t};
  endfunction

  task automatic run_op(input bit s, input bit o, input logic [7:0] x, input logic [7:0] y,
                        input int hold, output logic [8:0] rs, output logic rov, output int lat);
    int n;
    sel = s;
    n = 0;
    while (!in_ready_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_op", in_ready_m, 1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    op = 1'($urandom);
    lat = 0;
    while (!out_valid_m && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    repeat (hold) @(negedge clk);
    rs = sum_m;
    rov = ovf_m;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t tbl[10];
    logic [8:0] rs, held;
    logic rov;
    logic [9:0] m;
    int lat, n, acc[$];
    tbl[0] = '{0, 8'h0F, 8'h01, 9'h010, 0};
    tbl[1] = '{0, 8'h7F, 8'h01, 9'h080, 1};
    tbl[2] = '{0, 8'hFF, 8'h01, 9'h100, 0};
    tbl[3] = '{1, 8'h05, 8'h03, 9'h102, 0};
    tbl[4] = '{1, 8'h03, 8'h05, 9'h0FE, 0};
    tbl[5] = '{1, 8'h80, 8'h01, 9'h17F, 1};
    tbl[6] = '{0, 8'h9C, 8'h75, 9'h111, 0};
    tbl[7] = '{0, 8'hFF, 8'hFF, 9'h1FE, 0};
    tbl[8] = '{0, 8'h80, 8'h80, 9'h100, 1};
    tbl[9] = '{1, 8'h00, 8'h00, 9'h100, 0};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("reset_in_ready", in_ready_m, 1);
      check("reset_out_valid", out_valid_m, 0);
      check("reset_sum", sum_m, 0);
      check("reset_overflow", ovf_m, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 10; i++) begin
        run_op(1'(s), tbl[i].o, tbl[i].x, tbl[i].y, i % 3, rs, rov, lat);
        check($sformatf("vec%0d_c%0d_sum", i, s ? 4 : 1), rs, tbl[i].s);
        check($sformatf("vec%0d_c%0d_ovf", i, s ? 4 : 1), rov, tbl[i].v);
        check($sformatf("vec%0d_c%0d_latency", i, s ? 4 : 1), lat, s ? 2 : 8);
        check("idle_after_ack", in_ready_m, 1);
        check("valid_drop_after_ack", out_valid_m, 0);
      end

    // backpressure: result held for 5 cycles, extra in_valid pulses ignored
    sel = 1'b0;
    in_valid = 1'b1;
    op = 1'b0;
    a = 8'h12;
    b = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    held = sum_m;
    check("bp_first_sum", held, 9'h046);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid_m, 1);
      check("bp_sum_stable", sum_m, 9'h046);
      check("bp_in_ready_low", in_ready_m, 0);
      in_valid = 1'(i % 2);
      a = 8'hFF;
      b = 8'hFF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready_m, 1);
    check("bp_release_out_valid", out_valid_m, 0);
    repeat (12) @(negedge clk);
    check("bp_no_ghost_op", out_valid_m, 0);

    // reset mid-RUN after 3 chunks
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'h44;
    op = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready_m, 1);
    check("abort_out_valid", out_valid_m, 0);
    check("abort_sum", sum_m, 0);
    check("abort_overflow", ovf_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 1'b0, 8'h22, 8'h11, 0, rs, rov, lat);
    check("after_abort_sum", rs, 9'h033);
    check("after_abort_latency", lat, 8);

    // CHUNK=4 back-to-back throughput
    sel = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'h9C;
    b = 8'h75;
    op = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready_m) acc.push_back(i);
      if (out_valid_m) check("b2b_sum", sum_m, 9'h111);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_accept_count", acc.size(), 5);
    for (int i = 1; i < acc.size(); i++) check("b2b_period", acc[i] - acc[i-1], 4);
    n = 0;
    while (!in_ready_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    @(negedge clk);

    // randomized operations against the reference model
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 40; i++) begin
        logic [7:0] x, y;
        bit o;
        x = 8'($urandom);
        y = 8'($urandom);
        o = 1'($urandom);
        m = model(o, x, y);
        run_op(1'(s), o, x, y, int'($urandom_range(0, 3)), rs, rov, lat);
        check($sformatf("rand_c%0d_sum %0h%s%0h", s ? 4 : 1, x, o ? "-" : "+", y), rs, m[8:0]);
        check($sformatf("rand_c%0d_ovf %0h%s%0h", s ? 4 : 1, x, o ? "-" : "+", y), rov, m[9]);
        check("rand_latency", lat, s ? 2 : 8);
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
